// File: rtl/multicycle_core.sv
// Multi-cycle RV core subset: request, wait, execute; internal regfile,
// cycle/retire counters and sticky halt/trap status.
module multicycle_core #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000),
    parameter int              CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ifetch_req_valid,
    input  logic                 ifetch_req_ready,
    output logic [XLEN-1:0]      ifetch_addr,
    input  logic                 ifetch_rsp_valid,
    input  logic [31:0]          ifetch_rsp_inst,
    output logic [XLEN-1:0]      current_pc,
    output logic [XLEN-1:0]      next_pc,
    output logic                 retire,
    output logic                 halted,
    output logic [XLEN-1:0]      halt_code,
    output logic                 trap,
    output logic [31:0]          trap_inst,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    typedef enum logic [2:0] {
        S_FREQ,
        S_FWAIT,
        S_EXEC,
        S_HALT,
        S_TRAP
    } state_t;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [31:0]            inst_q, inst_d;
    logic                   halted_q, halted_d;
    logic [XLEN-1:0]        halt_code_q, halt_code_d;
    logic                   trap_q, trap_d;
    logic [31:0]            trap_inst_q, trap_inst_d;
    logic [CNT_WIDTH-1:0]   cycle_q;
    logic [CNT_WIDTH-1:0]   instret_q, instret_d;
    logic [XLEN-1:0]        rf_q [32];

    logic [6:0]             opc, f7;
    logic [4:0]             rd, rs1, rs2;
    logic [2:0]             f3;
    logic signed [11:0]     imm_i12;
    logic signed [31:0]     imm_u32;
    logic signed [20:0]     imm_j21;
    logic [XLEN-1:0]        imm_i, imm_u, imm_j;
    logic [XLEN-1:0]        rs1_v, rs2_v;
    logic                   is_lui, is_auipc, is_addi, is_add, is_sub;
    logic                   is_jal, is_jalr, is_ebreak, is_jump, legal;
    logic [XLEN-1:0]        pc_plus4, jalr_sum, jump_tgt, exec_npc;
    logic                   misalign;
    logic [XLEN-1:0]        wdata;
    logic                   writes, wen, ok, req_valid;

    assign opc = inst_q[6:0];
    assign rd  = inst_q[11:7];
    assign f3  = inst_q[14:12];
    assign rs1 = inst_q[19:15];
    assign rs2 = inst_q[24:20];
    assign f7  = inst_q[31:25];

    assign imm_i12 = inst_q[31:20];
    assign imm_u32 = {inst_q[31:12], 12'b0};
    assign imm_j21 = {inst_q[31], inst_q[19:12], inst_q[20],
                      inst_q[30:21], 1'b0};
    assign imm_i   = XLEN'(imm_i12);
    assign imm_u   = XLEN'(imm_u32);
    assign imm_j   = XLEN'(imm_j21);

    assign rs1_v = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_v = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    assign is_lui    = (opc == 7'b0110111);
    assign is_auipc  = (opc == 7'b0010111);
    assign is_addi   = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_add    = (opc == 7'b0110011) && (f3 == 3'b000)
                       && (f7 == 7'b0000000);
    assign is_sub    = (opc == 7'b0110011) && (f3 == 3'b000)
                       && (f7 == 7'b0100000);
    assign is_jal    = (opc == 7'b1101111);
    assign is_jalr   = (opc == 7'b1100111) && (f3 == 3'b000);
    assign is_ebreak = (inst_q == 32'h0010_0073);
    assign is_jump   = is_jal | is_jalr;
    assign legal     = is_lui | is_auipc | is_addi | is_add | is_sub
                       | is_jump | is_ebreak;

    // rs1_v is read before any write, so JALR with rs1==rd uses the old value
    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = rs1_v + imm_i;
    assign jump_tgt = is_jal ? (pc_q + imm_j)
                             : {jalr_sum[XLEN-1:1], 1'b0};
    assign misalign = is_jump & jump_tgt[1];
    assign exec_npc = is_jump ? jump_tgt : pc_plus4;

    always_comb begin
        wdata  = '0;
        writes = 1'b1;
        unique case (1'b1)
            is_lui:          wdata = imm_u;
            is_auipc:        wdata = pc_q + imm_u;
            is_addi:         wdata = rs1_v + imm_i;
            is_add:          wdata = rs1_v + rs2_v;
            is_sub:          wdata = rs1_v - rs2_v;
            is_jal, is_jalr: wdata = pc_plus4;
            default:         writes = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        halted_d    = halted_q;
        halt_code_d = halt_code_q;
        trap_d      = trap_q;
        trap_inst_d = trap_inst_q;
        instret_d   = instret_q;
        req_valid   = 1'b0;
        ok          = 1'b0;
        wen         = 1'b0;
        unique case (state_q)
            S_FREQ: begin
                req_valid = 1'b1;
                if (ifetch_req_ready) state_d = S_FWAIT;
            end
            S_FWAIT: begin
                if (ifetch_rsp_valid) begin
                    inst_d  = ifetch_rsp_inst;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!legal || misalign) begin
                    trap_d      = 1'b1;
                    trap_inst_d = inst_q;
                    state_d     = S_TRAP;
                end else begin
                    ok        = 1'b1;
                    instret_d = instret_q + CNT_WIDTH'(1);
                    wen       = writes && (rd != 5'd0);
                    if (is_ebreak) begin
                        halted_d    = 1'b1;
                        halt_code_d = rf_q[10];
                        state_d     = S_HALT;
                    end else begin
                        pc_d    = exec_npc;
                        state_d = S_FREQ;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FREQ;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            halted_q    <= 1'b0;
            halt_code_q <= '0;
            trap_q      <= 1'b0;
            trap_inst_q <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            halted_q    <= halted_d;
            halt_code_q <= halt_code_d;
            trap_q      <= trap_d;
            trap_inst_q <= trap_inst_d;
            cycle_q     <= cycle_q + CNT_WIDTH'(1);
            instret_q   <= instret_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wen) begin
            rf_q[rd] <= wdata;
        end
    end

    assign ifetch_req_valid = req_valid;
    assign ifetch_addr      = pc_q;
    assign current_pc       = pc_q;
    assign next_pc          = (state_q == S_EXEC) ? exec_npc : pc_q;
    assign retire           = ok;
    assign halted           = halted_q;
    assign halt_code        = halt_code_q;
    assign trap             = trap_q;
    assign trap_inst        = trap_inst_q;
    assign cycle_count      = cycle_q;
    assign instret_count    = instret_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: XLEN=64 and XLEN=32 instances in lockstep,
// program table plus hand-written stall/reset sequences.
module tb_multicycle_core;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0;
    logic rsp_v = 1'b0;
    logic [31:0] rsp_i = 32'h0;

    logic rv64, ret64, halted64, trap64;
    logic [63:0] addr64, cur64, nxt64, code64, cyc64, ins64;
    logic [31:0] tinst64;
    logic rv32, ret32, halted32, trap32;
    logic [31:0] addr32, cur32, nxt32, code32, tinst32;
    logic [63:0] cyc32, ins32;

    always #5 clk = ~clk;

    multicycle_core #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst),
        .ifetch_req_valid(rv64), .ifetch_req_ready(ready),
        .ifetch_addr(addr64), .ifetch_rsp_valid(rsp_v),
        .ifetch_rsp_inst(rsp_i), .current_pc(cur64), .next_pc(nxt64),
        .retire(ret64), .halted(halted64), .halt_code(code64),
        .trap(trap64), .trap_inst(tinst64),
        .cycle_count(cyc64), .instret_count(ins64)
    );

    multicycle_core #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut32 (
        .clk(clk), .rst(rst),
        .ifetch_req_valid(rv32), .ifetch_req_ready(ready),
        .ifetch_addr(addr32), .ifetch_rsp_valid(rsp_v),
        .ifetch_rsp_inst(rsp_i), .current_pc(cur32), .next_pc(nxt32),
        .retire(ret32), .halted(halted32), .halt_code(code32),
        .trap(trap32), .trap_inst(tinst32),
        .cycle_count(cyc32), .instret_count(ins32)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] e_addi(int rd, int rs1, int imm);
        logic [31:0] d, s, m;
        d = rd; s = rs1; m = imm;
        return {m[11:0], s[4:0], 3'b000, d[4:0], 7'b0010011};
    endfunction
    function automatic logic [31:0] e_rr(int rd, int rs1, int rs2, logic sub);
        logic [31:0] d, s, t;
        d = rd; s = rs1; t = rs2;
        return {1'b0, sub, 5'b0, t[4:0], s[4:0], 3'b000, d[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] e_u(int rd, int imm, logic aui);
        logic [31:0] d, m;
        d = rd; m = imm;
        return {m[19:0], d[4:0], aui ? 7'b0010111 : 7'b0110111};
    endfunction
    function automatic logic [31:0] e_jal(int rd, int off);
        logic [31:0] d, o;
        d = rd; o = off;
        return {o[20], o[10:1], o[11], o[19:12], d[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] e_jalr(int rd, int rs1, int imm);
        logic [31:0] d, s, m;
        d = rd; s = rs1; m = imm;
        return {m[11:0], s[4:0], 3'b000, d[4:0], 7'b1100111};
    endfunction

    typedef struct {
        string              name;
        logic [15:0][31:0]  prog;
        int                 n;
        logic [15:0][7:0]   roff;
        int                 nret;
        logic               halt;
        logic               trp;
        logic [63:0]        c64;
        logic [31:0]        c32;
        logic [31:0]        tinst;
        int                 eo;
    } vec_t;

    vec_t cur;
    vec_t vt[$];

    task automatic nv(string nm);
        cur.name = nm; cur.prog = '0; cur.n = 0;
        cur.roff = '0; cur.nret = 0;
    endtask
    task automatic w(logic [31:0] x);
        cur.prog[cur.n] = x; cur.n++;
    endtask
    task automatic r(int o);
        cur.roff[cur.nret] = 8'(o); cur.nret++;
    endtask
    task automatic ev(logic h, logic t, logic [63:0] c64, logic [31:0] c32,
                      logic [31:0] ti, int eo);
        cur.halt = h; cur.trp = t; cur.c64 = c64; cur.c32 = c32;
        cur.tinst = ti; cur.eo = eo;
        vt.push_back(cur);
    endtask

    // instruction memory model shared by both cores
    logic [31:0] mem [logic [63:0]];
    logic stall = 1'b0;
    logic inject = 1'b0;
    logic pend = 1'b0;
    logic [63:0] paddr = '0;

    initial forever begin
        @(negedge clk);
        ready = !stall;
        if (pend) begin
            rsp_v = 1'b1;
            rsp_i = mem.exists(paddr) ? mem[paddr] : 32'h0;
        end else if (inject) begin
            rsp_v = 1'b1;
            rsp_i = 32'h0;
        end else begin
            rsp_v = 1'b0;
            rsp_i = 32'h0;
        end
        pend  = !rst && rv64 && !stall;
        paddr = addr64;
    end

    // retire scoreboard
    logic [63:0] exp_q[$];
    int tcyc = 0;
    int last_ret = 0;
    logic have_last = 1'b0;

    initial forever begin
        @(posedge clk);
        tcyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst && (ret64 || ret32)) begin
            if (exp_q.size() == 0) begin
                chk("retire_unexpected", 64'(ret64), 64'(0));
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("retire_pc64", cur64, e);
                chk("retire_pc32", 64'(cur32), 64'(e[31:0]));
                chk("retire_both", 64'({ret64, ret32}), 64'(2'b11));
                if (have_last) chk("retire_gap", 64'(tcyc - last_ret), 64'(3));
            end
            last_ret  = tcyc;
            have_last = 1'b1;
        end
    end

    task automatic load(input vec_t v);
        mem.delete();
        for (int i = 0; i < v.n; i++) mem[BASE + 64'(4 * i)] = v.prog[i];
    endtask

    task automatic start(input vec_t v, input logic st);
        rst = 1'b1; stall = st; inject = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        for (int i = 0; i < v.nret; i++) exp_q.push_back(BASE + 64'(v.roff[i]));
        have_last = 1'b0;
        #1 rst = 1'b0;
    endtask

    task automatic wait_end(string nm);
        int c;
        c = 0;
        while (!(halted64 || trap64) && c < 300) begin
            @(posedge clk); #1; c++;
        end
        chk({nm, ".timeout"}, 64'(c < 300), 64'(1));
    endtask

    task automatic run_vec(input vec_t v);
        logic noreq;
        load(v);
        start(v, 1'b0);
        wait_end(v.name);
        noreq = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rv64 || rv32) noreq = 1'b0;
        end
        chk({v.name, ".no_req"}, 64'(noreq), 64'(1));
        chk({v.name, ".halted64"}, 64'(halted64), 64'(v.halt));
        chk({v.name, ".halted32"}, 64'(halted32), 64'(v.halt));
        chk({v.name, ".trap64"}, 64'(trap64), 64'(v.trp));
        chk({v.name, ".trap32"}, 64'(trap32), 64'(v.trp));
        chk({v.name, ".code64"}, code64, v.c64);
        chk({v.name, ".code32"}, 64'(code32), 64'(v.c32));
        chk({v.name, ".tinst64"}, 64'(tinst64), 64'(v.tinst));
        chk({v.name, ".tinst32"}, 64'(tinst32), 64'(v.tinst));
        chk({v.name, ".instret64"}, ins64, 64'(v.nret));
        chk({v.name, ".instret32"}, ins32, 64'(v.nret));
        chk({v.name, ".pc64"}, cur64, BASE + 64'(v.eo));
        chk({v.name, ".pc32"}, 64'(cur32), 64'(32'h8000_0000 + 32'(v.eo)));
        chk({v.name, ".sb_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zidx;
        vec_t v;
        logic [31:0] jw;
        int k;

        nv("addi_add");
        w(e_addi(1, 0, 5)); w(e_rr(2, 1, 1, 0)); w(e_rr(10, 2, 0, 0)); w(EBRK);
        r(0); r(4); r(8); r(12);
        ev(1, 0, 64'd10, 32'd10, 0, 12);

        nv("ebreak_m1");
        w(e_addi(10, 0, -1)); w(EBRK); r(0); r(4);
        ev(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0, 4);

        nv("jal");
        w(e_jal(1, 8)); w(32'h0); w(e_rr(10, 1, 0, 0)); w(EBRK);
        r(0); r(8); r(12);
        ev(1, 0, 64'h8000_0004, 32'h8000_0004, 0, 12);

        jw = e_jalr(0, 1, 2);
        nv("jalr_misalign");
        w(e_jal(1, 8)); w(32'h0); w(e_addi(10, 0, 7)); w(jw);
        r(0); r(8);
        ev(0, 1, 64'd0, 32'd0, jw, 12);

        nv("all_ones");
        w(32'hFFFF_FFFF);
        ev(0, 1, 64'd0, 32'd0, 32'hFFFF_FFFF, 0);

        nv("addi_twice");
        w(e_addi(3, 0, 'h7FF)); w(e_addi(3, 3, 'h7FF));
        w(e_rr(10, 3, 0, 0)); w(EBRK);
        r(0); r(4); r(8); r(12);
        ev(1, 0, 64'hFFE, 32'hFFE, 0, 12);

        nv("lui_addi");
        w(e_u(4, 'hFFFFF, 0)); w(e_addi(4, 4, -1));
        w(e_rr(10, 4, 0, 0)); w(EBRK);
        r(0); r(4); r(8); r(12);
        ev(1, 0, 64'hFFFF_FFFF_FFFF_EFFF, 32'hFFFF_EFFF, 0, 12);

        nv("x0_write");
        w(e_addi(0, 0, 5)); w(e_addi(10, 0, 3)); w(EBRK);
        r(0); r(4); r(8);
        ev(1, 0, 64'd3, 32'd3, 0, 8);

        nv("sub");
        w(e_addi(5, 0, 3)); w(e_rr(10, 0, 5, 1)); w(EBRK);
        r(0); r(4); r(8);
        ev(1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 32'hFFFF_FFFD, 0, 8);

        nv("auipc_wrap");
        w(e_u(10, 'h80001, 1)); w(EBRK); r(0); r(4);
        ev(1, 0, 64'h1000, 32'h1000, 0, 4);

        nv("jalr_rs1_eq_rd");
        w(e_u(1, 0, 1)); w(e_jalr(1, 1, 13)); w(32'h0);
        w(e_rr(10, 1, 0, 0)); w(EBRK);
        r(0); r(4); r(12); r(16);
        ev(1, 0, 64'h8000_0008, 32'h8000_0008, 0, 16);

        jw = e_rr(1, 1, 1, 0) | 32'h0000_1000;
        nv("bad_funct3");
        w(jw);
        ev(0, 1, 64'd0, 32'd0, jw, 0);

        zidx = vt.size();
        nv("zero_word");
        w(32'h0);
        ev(0, 1, 64'd0, 32'd0, 32'h0, 0);

        foreach (vt[i]) run_vec(vt[i]);

        // fetch request held off: address and state frozen
        v = vt[0];
        load(v);
        start(v, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        chk("stall.req64", 64'(rv64), 64'(1));
        chk("stall.req32", 64'(rv32), 64'(1));
        chk("stall.addr64", addr64, BASE);
        chk("stall.addr32", 64'(addr32), 64'(32'h8000_0000));
        chk("stall.next64", nxt64, BASE);
        chk("stall.next32", 64'(nxt32), 64'(32'h8000_0000));
        chk("stall.cycle64", cyc64, 64'd5);
        chk("stall.cycle32", cyc32, 64'd5);
        chk("stall.instret", ins64, 64'd0);
        stall = 1'b0;
        wait_end("stall");
        chk("stall.code64", code64, 64'd10);
        chk("stall.instret_end", ins64, 64'd4);

        // reset during FETCH_WAIT, then a stray response before a new request
        nv("midfetch");
        w(e_addi(10, 0, 9)); w(EBRK);
        v = cur;
        load(v);
        start(v, 1'b0);
        exp_q.delete();
        k = 0;
        while (rv64 && k < 10) begin @(posedge clk); #1; k++; end
        chk("midfetch.reached_wait", 64'(k < 10), 64'(1));
        rst = 1'b1; stall = 1'b1; inject = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midfetch.trap", 64'(trap64 | trap32), 64'(0));
        chk("midfetch.req", 64'(rv64), 64'(1));
        chk("midfetch.pc", cur64, BASE);
        chk("midfetch.instret", ins64, 64'd0);
        exp_q.push_back(BASE);
        exp_q.push_back(BASE + 64'd4);
        have_last = 1'b0;
        inject = 1'b0; stall = 1'b0;
        wait_end("midfetch");
        chk("midfetch.halted", 64'(halted64 & halted32), 64'(1));
        chk("midfetch.code64", code64, 64'd9);
        chk("midfetch.code32", 64'(code32), 64'd9);
        chk("midfetch.trap_end", 64'(trap64 | trap32), 64'(0));

        // trap cleared by a single reset cycle
        run_vec(vt[zidx]);
        rst = 1'b1; stall = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("trap_rst.trap64", 64'(trap64), 64'(0));
        chk("trap_rst.trap32", 64'(trap32), 64'(0));
        chk("trap_rst.tinst", 64'(tinst64), 64'(0));
        chk("trap_rst.req", 64'(rv64 & rv32), 64'(1));
        chk("trap_rst.addr", addr64, BASE);
        chk("trap_rst.cycle", cyc64, 64'd0);
        chk("trap_rst.instret", ins64, 64'd0);
        stall = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle RV successor to the single-cycle top. Fetches one instruction at a time over a valid/ready request and valid response interface, then executes it in a single EXECUTE cycle.
- Contains an internal 32-entry register file, a PC, retire and cycle counters, and a sticky halt/trap status.
- Sits between the instruction memory model and the DPI simulation harness. The harness polls `halted`/`trap` and no longer calls DPI from inside the core.

Parameters:
- XLEN, 64, register, PC and ALU width (32 or 64).
- RESET_PC, 'h8000_0000, PC value loaded on reset (XLEN wide).
- CNT_WIDTH, 64, width of `cycle_count` and `instret_count`.

Ports:
- clk  in  1  core clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- ifetch_req_valid  out  1  fetch request valid.
- ifetch_req_ready  in  1  memory accepts request.
- ifetch_addr  out  XLEN  fetch address, equals current_pc.
- ifetch_rsp_valid  in  1  instruction word valid.
- ifetch_rsp_inst  in  32  instruction word.
- current_pc  out  XLEN  PC of the instruction being fetched or executed.
- next_pc  out  XLEN  PC that will be fetched next.
- retire  out  1  one-cycle pulse per retired instruction.
- halted  out  1  sticky, set by EBREAK.
- halt_code  out  XLEN  x10 (a0) value captured at EBREAK.
- trap  out  1  sticky, illegal instruction or misaligned jump.
- trap_inst  out  32  offending instruction word.
- cycle_count  out  CNT_WIDTH  cycles since reset.
- instret_count  out  CNT_WIDTH  retired instructions.

Behaviour:
- Reset (rst=1 at posedge):
  - state=FETCH_REQ, current_pc=RESET_PC, all x-registers=0.
  - halted=0, trap=0, halt_code=0, trap_inst=0, retire=0.
  - Both counters=0.
  - Reset mid-fetch abandons the request; a response arriving after reset but before a new request is accepted is ignored.
- State FETCH_REQ:
  - ifetch_req_valid=1.
  - On ifetch_req_ready=1 go to FETCH_WAIT; otherwise hold. Address stays stable while waiting.
- State FETCH_WAIT:
  - req_valid=0.
  - On ifetch_rsp_valid=1 latch the instruction word and go to EXECUTE.
  - A response is never accepted in the same cycle as its request. rsp_valid outside FETCH_WAIT is ignored.
- State EXECUTE (exactly 1 cycle):
  - Decode, read rs1/rs2, compute, write rd, update PC, go to FETCH_REQ.
  - Writes to x0 are discarded and x0 always reads 0.
  - retire=1 and instret_count increments in this cycle for every legal, non-trapping instruction, including EBREAK.
- Supported instructions:
  - LUI, AUIPC, ADDI, ADD, SUB, JAL, JALR, EBREAK.
  - Immediates are sign-extended to XLEN. All arithmetic wraps modulo 2^XLEN.
  - JAL/JALR write pc+4 to rd. JALR target is (rs1+imm) with bit0 cleared.
  - If rs1==rd on JALR, the old rs1 value is used for the target.
- Minimum latency is 3 cycles per instruction (FETCH_REQ, FETCH_WAIT, EXECUTE) when ready and rsp are immediate.
- next_pc:
  - In EXECUTE: the computed target, or pc+4 for non-jumps.
  - In every other state: current_pc.
- EBREAK: in EXECUTE, capture x10 into halt_code, set halted, enter HALT. current_pc stays at the EBREAK address.
- Trap conditions:
  - Any other encoding, including all-zeros and all-ones words.
  - A jump target with bit1 set.
- On a trap: no register write, no retire, PC unchanged, trap=1, trap_inst=word, enter TRAP.
- HALT and TRAP are terminal until rst:
  - ifetch_req_valid=0 and retire=0.
  - cycle_count keeps counting.
- cycle_count increments every non-reset cycle and wraps at 2^CNT_WIDTH. instret_count also wraps.
- With XLEN=32, AUIPC/LUI results are 32-bit and no upper sign extension beyond XLEN applies.

Test Plan:
- Reset with ready=1 and 1-cycle response, execute ADDI x1,x0,5 then ADD x2,x1,x1 → x2=10, instret=2, retire pulses 3 cycles apart, first fetch addr 0x8000_0000.
- Hold ifetch_req_ready=0 for 5 cycles → req_valid and addr stable at 0x8000_0000, no state change, cycle_count=5.
- ADDI x10,x0,-1 then EBREAK → halted=1, halt_code=0xFFFF_FFFF_FFFF_FFFF, instret=2, no further requests over 20 cycles.
- JAL x1,+8 at 0x8000_0000 → x1=0x8000_0004, next fetch 0x8000_0008. JALR x0,x1,2 → trap=1, trap_inst matches, x-registers unchanged.
- Word 0x0000_0000 → trap=1, retire never asserted. Then rst=1 for 1 cycle → trap=0, fetch restarts at RESET_PC.
- XLEN=32: ADDI x3,x0,0x7FF executed twice into x3 (x3=x3+0x7FF) → 0xFFE. LUI x4,0xFFFFF then ADDI x4,x4,-1 → 0xFFFF_EFFF. ADDI to x0 → x0 still reads 0.
